display_writer: RTL

DISPLAY_WRITER -- requirements
Module: display_writer

---
 rtl/display_writer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/display_writer.sv
`default_nettype none
// ============================================================================
//  Module      : display_writer
//  Description : Streams RGB pixels into one of two display frame buffers.
//                Buffers are written in strict alternation (0,1,0,1,...).
//                Each frame waits for its target buffer's empty flag, accepts
//                FRAME_PX pixels through a valid/ready handshake, writes each
//                one a cycle after acceptance, then pulses FrameDone.
//  Parameters  : ACTIVE_PX    - active pixels per line
//                ACTIVE_LINES - active lines per frame
//                (FRAME_PX = ACTIVE_PX*ACTIVE_LINES, legal range 2..2^20)
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous, active-high reset
//                PixValid   - source pixel valid
//                PixR/G/B   - 8-bit colour components
//                PixReady   - writer accepts the pixel this cycle
//                Buf0Empty  - display buffer 0 free for writing
//                Buf1Empty  - display buffer 1 free for writing
//                WData      - write word {8'h00, R, G, B}
//                WAddr      - pixel address within the target buffer
//                WE0 / WE1  - write strobes for buffer 0 / buffer 1
//                CSDisplay  - display adapter chip select
//                FrameDone  - one-cycle pulse after the last pixel is written
//                CurBuf     - buffer currently targeted
//  Revision    : 1.0 - initial release
// ============================================================================
module display_writer #(
    parameter int ACTIVE_PX    = 640,
    parameter int ACTIVE_LINES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PixValid,
    input  logic [7:0]  PixR,
    input  logic [7:0]  PixG,
    input  logic [7:0]  PixB,
    output logic        PixReady,
    input  logic        Buf0Empty,
    input  logic        Buf1Empty,
    output logic [31:0] WData,
    output logic [19:0] WAddr,
    output logic        WE0,
    output logic        WE1,
    output logic        CSDisplay,
    output logic        FrameDone,
    output logic        CurBuf
);

    localparam int FRAME_PX = ACTIVE_PX * ACTIVE_LINES;

    // The last pixel index always fits in the 20-bit counter because
    // FRAME_PX is bounded by 2^20.
    localparam logic [19:0] c_LAST_PX = 20'(FRAME_PX - 1);

    localparam logic [1:0] c_WAIT_BUF = 2'd0;
    localparam logic [1:0] c_WRITE    = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;

    logic [1:0]  r_state;
    logic        r_cur_buf;
    logic [19:0] r_cnt;
    logic [31:0] r_wdata;
    logic [19:0] r_waddr;
    logic        r_we0;
    logic        r_we1;
    logic        r_cs;

    // Only the flag of the buffer in turn matters; the other is ignored even
    // when it is also empty, which keeps the alternation strict.
    logic w_buf_empty;
    assign w_buf_empty = r_cur_buf ? Buf1Empty : Buf0Empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_WAIT_BUF;
            r_cur_buf <= 1'b0;
            r_cnt     <= 20'd0;
            r_wdata   <= 32'd0;
            r_waddr   <= 20'd0;
            r_we0     <= 1'b0;
            r_we1     <= 1'b0;
            r_cs      <= 1'b0;
        end else begin
            // Strobes are single-cycle; data and address hold between beats.
            r_we0 <= 1'b0;
            r_we1 <= 1'b0;
            r_cs  <= 1'b0;
            case (r_state)
                c_WAIT_BUF: begin
                    if (w_buf_empty) begin
                        r_state <= c_WRITE;
                        r_cnt   <= 20'd0;
                    end
                end
                c_WRITE: begin
                    // Ready is asserted throughout WRITE, so valid alone
                    // means a beat is accepted on this edge.
                    if (PixValid) begin
                        r_wdata <= {8'h00, PixR, PixG, PixB};
                        r_waddr <= r_cnt;
                        r_we0   <= ~r_cur_buf;
                        r_we1   <= r_cur_buf;
                        r_cs    <= 1'b1;
                        r_cnt   <= r_cnt + 20'd1;
                        if (r_cnt == c_LAST_PX) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_cur_buf <= ~r_cur_buf;
                    r_cnt     <= 20'd0;
                    r_state   <= c_WAIT_BUF;
                end
                default: begin
                    r_state <= c_WAIT_BUF;
                end
            endcase
        end
    end

    assign PixReady  = (r_state == c_WRITE);
    // DONE lasts exactly one cycle, the same cycle as the final strobe.
    assign FrameDone = (r_state == c_DONE);
    assign CurBuf    = r_cur_buf;
    assign WData     = r_wdata;
    assign WAddr     = r_waddr;
    assign WE0       = r_we0;
    assign WE1       = r_we1;
    assign CSDisplay = r_cs;

endmodule
`default_nettype wire
